// File: rtl/simple_io_pkg.sv
// Shared constants and sizing helper for the SIMPLE I/O stage.
// Pure declarations: no latency, no backpressure.
package simple_io_pkg;

    localparam int WORD_W           = 16;
    localparam int DEFAULT_IO_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/simple_io_fifo.sv
// DEPTH-entry synchronous FIFO; a write is visible at the head one edge later.
// A push while full or a pop while empty is ignored; storage is never cleared.
module simple_io_fifo #(
    parameter int DEPTH  = simple_io_pkg::DEFAULT_IO_DEPTH,
    parameter int WORD_W = simple_io_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    import simple_io_pkg::*;

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage has no reset; the write is still suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simple_io_unit.sv
// SIMPLE core I/O stage: OUT words buffered and drained over valid/ready; IN words held one-deep.
// One-edge latency both ways; io_stall freezes the core on a full FIFO or an empty holding reg. IO_COUNT_EN adds tx/rx counters.
module simple_io_unit #(
    parameter int DEPTH  = simple_io_pkg::DEFAULT_IO_DEPTH,
    parameter int WORD_W = simple_io_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              out_we,
    input  logic [WORD_W-1:0] out_data,
    input  logic              in_rd,
    output logic [WORD_W-1:0] in_data,
    output logic              in_avail,
    output logic              io_stall,
    output logic              ext_out_valid,
    output logic [WORD_W-1:0] ext_out_data,
    input  logic              ext_out_ready,
    input  logic              ext_in_valid,
    input  logic [WORD_W-1:0] ext_in_data,
    output logic              ext_in_ready
`ifdef IO_COUNT_EN
    ,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
`endif
);
    import simple_io_pkg::*;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              capture;
    logic [WORD_W-1:0] holding;

    simple_io_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (out_we),
        .push_data (out_data),
        .pop       (pop),
        .head_data (ext_out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ext_out_valid = !fifo_empty;
    assign pop           = ext_out_valid && ext_out_ready;

    // A read in the same cycle frees the slot, so a new word can land immediately.
    assign ext_in_ready = !in_avail || in_rd;
    assign capture      = ext_in_valid && ext_in_ready;
    assign in_data      = holding;

    assign io_stall = (out_we && fifo_full) || (in_rd && !in_avail);

    always_ff @(posedge clk) begin
        if (reset) begin
            holding  <= '0;
            in_avail <= 1'b0;
        end else if (capture) begin
            holding  <= ext_in_data;
            in_avail <= 1'b1;
        end else if (in_rd) begin
            in_avail <= 1'b0;
        end
    end

`ifdef IO_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (pop) begin
                tx_count <= tx_count + 1'b1;
            end
            if (capture) begin
                rx_count <= rx_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simple_io_unit.sv
// Directed and randomized checks of simple_io_unit against a queue-based reference model.
module tb_simple_io_unit;
    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         out_we;
    logic [W-1:0] out_data;
    logic         in_rd;
    logic [W-1:0] in_data;
    logic         in_avail;
    logic         io_stall;
    logic         ext_out_valid;
    logic [W-1:0] ext_out_data;
    logic         ext_out_ready;
    logic         ext_in_valid;
    logic [W-1:0] ext_in_data;
    logic         ext_in_ready;
`ifdef IO_COUNT_EN
    logic [15:0]  tx_count;
    logic [15:0]  rx_count;
`endif

    simple_io_unit #(.DEPTH(DEPTH), .WORD_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .out_we        (out_we),
        .out_data      (out_data),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_avail      (in_avail),
        .io_stall      (io_stall),
        .ext_out_valid (ext_out_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready),
        .ext_in_valid  (ext_in_valid),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready)
`ifdef IO_COUNT_EN
        ,
        .tx_count      (tx_count),
        .rx_count      (rx_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: output buffer as a queue, input slot as word + flag.
    logic [W-1:0] mq[$];
    logic [W-1:0] mhold = '0;
    logic         mavail = 1'b0;
    int           mtx = 0;
    int           mrx = 0;

    task automatic model_update();
        bit do_pop, do_push, do_cap;
        if (reset) begin
            mq.delete();
            mhold  = '0;
            mavail = 1'b0;
            mtx    = 0;
            mrx    = 0;
        end else begin
            do_pop  = (mq.size() > 0) && ext_out_ready;
            do_push = out_we && (mq.size() < DEPTH);
            do_cap  = ext_in_valid && (!mavail || in_rd);
            if (do_pop) begin
                void'(mq.pop_front());
                mtx = (mtx + 1) % 65536;
            end
            if (do_push) mq.push_back(out_data);
            if (do_cap) begin
                mhold  = ext_in_data;
                mavail = 1'b1;
                mrx    = (mrx + 1) % 65536;
            end else if (in_rd) begin
                mavail = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset         = 1'b0;
        out_we        = 1'b0;
        out_data      = '0;
        in_rd         = 1'b0;
        ext_out_ready = 1'b0;
        ext_in_valid  = 1'b0;
        ext_in_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        out_we = 1'b1; out_data = 16'hDEAD; ext_in_valid = 1'b1; ext_in_data = 16'hBEEF;
        tick();
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ext_out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", ext_out_valid); else passed++;
        checks++; if (ext_out_data !== 16'h0) $display("FAIL reset_out_data got %h want 0000", ext_out_data); else passed++;
        checks++; if (in_avail !== 1'b0) $display("FAIL reset_in_avail got %0b want 0", in_avail); else passed++;
        checks++; if (in_data !== 16'h0) $display("FAIL reset_in_data got %h want 0000", in_data); else passed++;
        checks++; if (ext_in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", ext_in_ready); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", io_stall); else passed++;
    endtask

    task automatic test_fifo_order();
        logic [W-1:0] words [3];
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'h0001;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            out_we = 1'b1; out_data = words[i];
            #1;
            tick();
        end
        out_we = 1'b0;
        #1;
        checks++; if ({ext_out_valid, ext_out_data} !== {1'b1, 16'h1234})
            $display("FAIL order_head got %0b/%h want 1/1234", ext_out_valid, ext_out_data); else passed++;
        ext_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({ext_out_valid, ext_out_data} !== {1'b1, words[i]})
                $display("FAIL order_drain%0d got %0b/%h want 1/%h", i, ext_out_valid, ext_out_data, words[i]); else passed++;
            tick();
        end
        #1;
        checks++; if ({ext_out_valid, ext_out_data} !== {1'b0, 16'h0})
            $display("FAIL order_empty got %0b/%h want 0/0000", ext_out_valid, ext_out_data); else passed++;
        ext_out_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [W-1:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            out_we = 1'b1; out_data = W'(i);
            #1;
            tick();
        end
        out_data = 16'h00FF;
        #1;
        checks++; if (io_stall !== 1'b1) $display("FAIL full_stall got %0b want 1", io_stall); else passed++;
        tick();
        checks++; if (io_stall !== 1'b1) $display("FAIL full_stall_hold got %0b want 1", io_stall); else passed++;
        ext_out_ready = 1'b1;
        #1;
        checks++; if (io_stall !== 1'b1) $display("FAIL full_stall_on_pop got %0b want 1", io_stall); else passed++;
        tick();
        ext_out_ready = 1'b0;
        #1;
        checks++; if (io_stall !== 1'b0) $display("FAIL full_retry_stall got %0b want 0", io_stall); else passed++;
        tick();
        out_we = 1'b0;
        ext_out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            exp = (i == DEPTH) ? 16'h00FF : W'(i);
            #1;
            checks++; if ({ext_out_valid, ext_out_data} !== {1'b1, exp})
                $display("FAIL full_drain%0d got %0b/%h want 1/%h", i, ext_out_valid, ext_out_data, exp); else passed++;
            tick();
        end
        #1;
        checks++; if (ext_out_valid !== 1'b0) $display("FAIL full_drained got %0b want 0", ext_out_valid); else passed++;
        ext_out_ready = 1'b0;
    endtask

    task automatic test_holding();
        do_reset();
        ext_in_valid = 1'b1; ext_in_data = 16'h5A5A;
        #1;
        tick();
        ext_in_valid = 1'b0;
        #1;
        checks++; if ({in_avail, in_data, ext_in_ready} !== {1'b1, 16'h5A5A, 1'b0})
            $display("FAIL hold_capture got %0b/%h/%0b want 1/5a5a/0", in_avail, in_data, ext_in_ready); else passed++;
        ext_in_valid = 1'b1; ext_in_data = 16'h0F0F; in_rd = 1'b1;
        #1;
        checks++; if ({ext_in_ready, io_stall} !== 2'b10)
            $display("FAIL hold_b2b_ready got %0b/%0b want 1/0", ext_in_ready, io_stall); else passed++;
        tick();
        ext_in_valid = 1'b0; in_rd = 1'b0;
        #1;
        checks++; if ({in_avail, in_data} !== {1'b1, 16'h0F0F})
            $display("FAIL hold_replace got %0b/%h want 1/0f0f", in_avail, in_data); else passed++;
        in_rd = 1'b1;
        #1;
        tick();
        in_rd = 1'b0;
        #1;
        checks++; if ({in_avail, in_data, ext_in_ready} !== {1'b0, 16'h0F0F, 1'b1})
            $display("FAIL hold_consume got %0b/%h/%0b want 0/0f0f/1", in_avail, in_data, ext_in_ready); else passed++;
    endtask

    task automatic test_in_stall();
        do_reset();
        in_rd = 1'b1;
        #1;
        checks++; if (io_stall !== 1'b1) $display("FAIL install_raise got %0b want 1", io_stall); else passed++;
        tick();
        checks++; if ({io_stall, in_avail, in_data} !== {1'b1, 1'b0, 16'h0})
            $display("FAIL install_nochange got %0b/%0b/%h want 1/0/0000", io_stall, in_avail, in_data); else passed++;
        ext_in_valid = 1'b1; ext_in_data = 16'h7777;
        #1;
        checks++; if ({io_stall, ext_in_ready} !== 2'b11)
            $display("FAIL install_offer got %0b/%0b want 1/1", io_stall, ext_in_ready); else passed++;
        tick();
        ext_in_valid = 1'b0;
        #1;
        checks++; if ({io_stall, in_avail, in_data} !== {1'b0, 1'b1, 16'h7777})
            $display("FAIL install_release got %0b/%0b/%h want 0/1/7777", io_stall, in_avail, in_data); else passed++;
        tick();
        in_rd = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [W-1:0] exp_head;
        bit           exp_stall;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 79) == 0);
            out_we        = ($urandom_range(0, 2) != 0);
            out_data      = W'($urandom);
            in_rd         = $urandom_range(0, 1) != 0;
            ext_out_ready = ($urandom_range(0, 2) == 0) ^ (c[7]);
            ext_in_valid  = $urandom_range(0, 1) != 0;
            ext_in_data   = W'($urandom);
            #1;
            exp_head  = (mq.size() > 0) ? mq[0] : '0;
            exp_stall = (out_we && mq.size() == DEPTH) || (in_rd && !mavail);
            checks++;
            if ({ext_out_valid, ext_out_data, in_avail, in_data, io_stall, ext_in_ready} !==
                {(mq.size() > 0), exp_head, mavail, mhold, exp_stall, (!mavail || in_rd)})
                $display("FAIL random_cycle%0d got v%0b d%h a%0b i%h s%0b r%0b want v%0b d%h a%0b i%h s%0b r%0b",
                         c, ext_out_valid, ext_out_data, in_avail, in_data, io_stall, ext_in_ready,
                         (mq.size() > 0), exp_head, mavail, mhold, exp_stall, (!mavail || in_rd));
            else passed++;
`ifdef IO_COUNT_EN
            checks++;
            if ({tx_count, rx_count} !== {16'(mtx), 16'(mrx)})
                $display("FAIL random_counters%0d got %h/%h want %h/%h", c, tx_count, rx_count, 16'(mtx), 16'(mrx));
            else passed++;
`endif
            tick();
        end
        idle_inputs();
    endtask

`ifdef IO_COUNT_EN
    task automatic test_counters();
        int guard;
        do_reset();
        ext_in_valid = 1'b1; in_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_in_data = W'(16'h0100 + i);
            #1;
            tick();
        end
        ext_in_valid = 1'b0; in_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_we = 1'b1; out_data = W'(i);
            #1;
            tick();
        end
        out_we = 1'b0; ext_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tick();
        end
        ext_out_ready = 1'b0;
        #1;
        checks++; if ({tx_count, rx_count} !== {16'd5, 16'd3})
            $display("FAIL count_basic got %0d/%0d want 5/3", tx_count, rx_count); else passed++;
        // Streams one pop per cycle until the counter sits at its maximum.
        out_we = 1'b1; ext_out_ready = 1'b1; out_data = 16'hC0DE;
        guard = 0;
        while (mtx != 16'hFFFF && guard < 70000) begin
            #1;
            tick();
            guard++;
        end
        checks++; if (tx_count !== 16'hFFFF) $display("FAIL count_max got %h want ffff", tx_count); else passed++;
        tick();
        checks++; if (tx_count !== 16'h0000) $display("FAIL count_wrap got %h want 0000", tx_count); else passed++;
        ext_in_valid = 1'b1; ext_in_data = 16'h4242;
        #1;
        tick();
        reset = 1'b1;
        #1;
        tick();
        idle_inputs();
        #1;
        checks++; if ({tx_count, rx_count} !== 32'h0)
            $display("FAIL count_reset got %h/%h want 0000/0000", tx_count, rx_count); else passed++;
        checks++; if ({ext_out_valid, in_avail, in_data} !== {1'b0, 1'b0, 16'h0})
            $display("FAIL count_reset_state got %0b/%0b/%h want 0/0/0000", ext_out_valid, in_avail, in_data); else passed++;
    endtask
`endif

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_fifo_order();
        test_full();
        test_holding();
        test_in_stall();
        test_random();
`ifdef IO_COUNT_EN
        test_counters();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/simple_io_unit.md
Name: simple_io_unit

Overview:
- Output-side I/O stage directly downstream of the SIMPLE core's OUT path, plus the input holding stage feeding its IN path.
- OUT words from the core are buffered in a FIFO and drained to an external consumer over valid/ready.
- External IN words are captured into a one-entry holding register that the core reads; the block raises a stall when the core cannot proceed.

Parameters:
- DEPTH, 8, output FIFO entries; power of two, >= 2
- WORD_W, 16, data word width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- out_we  in  1  core OUT strobe, one cycle per word
- out_data  in  WORD_W  word to emit
- in_rd  in  1  core IN strobe, consumes held input word
- in_data  out  WORD_W  held input word presented to core
- in_avail  out  1  holding register contains a valid word
- io_stall  out  1  combinational; core must freeze its phase counter
- ext_out_valid  out  1  FIFO head valid
- ext_out_data  out  WORD_W  FIFO head word
- ext_out_ready  in  1  external consumer accepts head
- ext_in_valid  in  1  external producer offers a word
- ext_in_data  in  WORD_W  offered word
- ext_in_ready  out  1  block accepts offered word this cycle

Behaviour:
- Reset, sampled on a clk edge with reset=1: wr_ptr=rd_ptr=count=0, in_avail=0, holding reg=0. Result: ext_out_valid=0, ext_out_data=0, in_data=0, ext_in_ready=1, io_stall=0 (unless a strobe is asserted with its resource unavailable). FIFO storage is not cleared.
- Reset has priority over every push, pop and capture in the same cycle. Reset mid-transfer discards all buffered words.
- Output FIFO:
  - full = (count==DEPTH), empty = (count==0). count width is clog2(DEPTH+1).
  - Push when out_we && !full: mem[wr_ptr]<=out_data, wr_ptr increments, wrapping modulo DEPTH.
  - Pop when ext_out_valid && ext_out_ready: rd_ptr increments, wrapping modulo DEPTH.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full is rejected, even if a pop occurs that cycle; the core retries after the stall.
  - ext_out_valid = !empty. ext_out_data = mem[rd_ptr] when !empty, else 0.
  - Latency: a word pushed at edge N is visible on ext_out_* after edge N, assuming the FIFO was empty.
  - The head word holds stable while valid && !ready.
- Input holding register:
  - ext_in_ready = !in_avail || in_rd.
  - Capture when ext_in_valid && ext_in_ready: holding<=ext_in_data, in_avail<=1.
  - in_rd && in_avail with no capture: in_avail<=0.
  - in_rd with a simultaneous capture: the new word replaces the old one and in_avail stays 1. This gives back-to-back throughput of 1 word/cycle.
  - in_rd while !in_avail has no state effect.
  - in_data = holding register at all times.
- io_stall = (out_we && full) || (in_rd && !in_avail).
  - The core holds its strobe asserted until io_stall drops.
  - The block takes no duplicate action while stalled.

Optional Feature:
- Macro IO_COUNT_EN.
- When defined:
  - Adds output ports tx_count and rx_count, each 16 bits.
  - tx_count increments on each FIFO pop; rx_count increments on each capture.
  - Both wrap 0xFFFF->0x0000 and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package simple_io_pkg holds:
  - WORD_W=16
  - DEFAULT_IO_DEPTH=8
  - a ptr-width helper function
- One sub-module, simple_io_fifo: the DEPTH-entry synchronous FIFO with push/pop/full/empty/count.
- The holding register, stall logic and counters stay in the top module.

Test Plan:
- Reset, then idle: ext_out_valid=0, ext_out_data=0, in_avail=0, ext_in_ready=1, io_stall=0.
- Push 0x1234, 0xABCD, 0x0001 with ext_out_ready=0: count=3 and head=0x1234. Raise ready: the three words appear in order on consecutive cycles, then valid=0.
- Fill 8 words (0x0000..0x0007) with ready=0, then assert out_we with 0x00FF: io_stall=1 and count stays 8. Pop once, then retry: accepted, and 0x00FF is drained last after 0x0007.
- ext_in_valid with 0x5A5A: in_avail=1, in_data=0x5A5A, ext_in_ready=0. Offer 0x0F0F while in_rd=1: 0x0F0F is captured in the same cycle and in_avail stays 1.
- in_rd with in_avail=0: io_stall=1 and no state change. Then present 0x7777: io_stall drops the cycle after capture.
- With IO_COUNT_EN: 5 pops and 3 captures give tx_count=5 and rx_count=3. Preload via 0x10000 pops to check the 0xFFFF->0 wrap. Assert reset mid-stream: counters, FIFO and holding register all clear.
